// File: rtl/srl_test_pkg.sv
// Shared definitions for the SRL16 test generator and checker: LFSR taps, seed, FSM states.
// Both ends use lfsr_next so the regenerated stream cannot drift from the driven one.
package srl_test_pkg;

    localparam int                LFSR_W       = 16;
    // Feedback taps at bits 15, 13, 12 and 10
    localparam logic [LFSR_W-1:0] TAP_MASK     = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/srl_shift_checker_if.sv
// Control, data-in and result signals between the SRL test harness and the checker.
interface srl_shift_checker_if #(
    parameter int LANES = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             clear;
    logic             din_valid;
    logic [LANES-1:0] din;
    logic [LANES-1:0] error;
    logic [CNT_W-1:0] err_count;
    logic             busy;
    logic             done;

    modport master (
        output start, clear, din_valid, din,
        input  error, err_count, busy, done
    );

    modport slave (
        input  start, clear, din_valid, din,
        output error, err_count, busy, done
    );
endinterface

// File: rtl/srl_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; the generator side instantiates the same module.
module srl_lfsr16
    import srl_test_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/srl_shift_checker.sv
// Receive-side checker for SRL delay-line tests: skips the fill latency, then compares
// each lane against a locally regenerated LFSR stream and accumulates sticky errors.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   WAIT  | counting DELAY valid beats of fill latency, no compare
//   CHECK | comparing CHECK_BEATS valid beats against the LFSR
//   DONE  | run finished; results frozen until clear or the next start
module srl_shift_checker
    import srl_test_pkg::*;
#(
    parameter int                LANES       = 8,
    parameter int                DELAY       = 16,
    parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED,
    parameter int                CHECK_BEATS = 1024,
    parameter int                CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    srl_shift_checker_if.slave  bus
);

    localparam int BEAT_W = $clog2(CHECK_BEATS + 1);

    chk_state_e        state_q, state_d;
    logic [7:0]        wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LANES-1:0]  error_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [LANES-1:0]  mism;
    logic              lfsr_load;
    logic              lfsr_en;
    logic              chk_beat;
    logic              wait_last;
    logic              beat_last;

    srl_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .load  (lfsr_load),
        .seed  (SEED),
        .state (lfsr_q)
    );

    assign mism      = bus.din ^ lfsr_q[LANES-1:0];
    assign wait_last = (wait_cnt + 8'd1) == 8'(DELAY);
    assign beat_last = beat_cnt == BEAT_W'(CHECK_BEATS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clear wins over everything, so start in the same cycle is dropped
    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        chk_beat  = 1'b0;
        if (bus.clear) begin
            state_d   = IDLE;
            lfsr_load = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d   = WAIT;
                        lfsr_load = 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.din_valid && wait_last) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (bus.din_valid) begin
                        chk_beat = 1'b1;
                        lfsr_en  = 1'b1;
                        if (beat_last) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else if (lfsr_load) begin
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (state_q == WAIT && bus.din_valid) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (chk_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // One count per mismatching beat, not per bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q   <= '0;
            err_cnt_q <= '0;
        end else if (bus.clear) begin
            error_q   <= '0;
            err_cnt_q <= '0;
        end else if (chk_beat) begin
            error_q <= error_q | mism;
            if ((|mism) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.error     = error_q;
    assign bus.err_count = err_cnt_q;
    assign bus.busy      = (state_q == WAIT) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_srl_shift_checker.sv
// Directed bench for srl_shift_checker: a table of run steps with expected outputs,
// plus hand-written sequences for start-up, saturation, latency and mid-run reset.
module tb_srl_shift_checker;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int OP_START  = 0;
    localparam int OP_CLEAR  = 1;
    localparam int OP_FILL   = 2;
    localparam int OP_STREAM = 3;
    localparam int NSTEPS    = 17;

    typedef struct {
        int          op;
        int          n;
        int          gap;
        int          bad_beat;
        logic [7:0]  bad_mask;
        logic        exp_busy;
        logic        exp_done;
        logic [7:0]  exp_err;
        logic [15:0] exp_cnt;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    int          m_beat;
    step_t       steps [NSTEPS];

    srl_shift_checker_if #(.LANES(8), .CNT_W(16)) bus ();
    srl_shift_checker_if #(.LANES(8), .CNT_W(4))  bus4 ();

    // Second checker sees every lane inverted to exercise counter saturation
    assign bus4.start     = bus.start;
    assign bus4.clear     = bus.clear;
    assign bus4.din_valid = bus.din_valid;
    assign bus4.din       = ~bus.din;

    srl_shift_checker #(.LANES(8), .DELAY(16), .SEED(SEED), .CHECK_BEATS(1024), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    srl_shift_checker #(.LANES(8), .DELAY(16), .SEED(SEED), .CHECK_BEATS(1024), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic busy, input logic done,
                           input logic [7:0] err, input logic [15:0] cnt);
        chk({tag, " busy"},      32'(bus.busy),      32'(busy));
        chk({tag, " done"},      32'(bus.done),      32'(done));
        chk({tag, " error"},     32'(bus.error),     32'(err));
        chk({tag, " err_count"}, 32'(bus.err_count), 32'(cnt));
    endtask

    task automatic beat(input logic [7:0] d);
        bus.din_valid = 1'b1;
        bus.din       = d;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_lfsr = SEED;
        m_beat = 0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic do_fill(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            beat(8'h5A ^ 8'(i));
            repeat (gap) tick();
        end
    endtask

    task automatic do_stream(input int n, input int gap, input int bad_beat, input logic [7:0] bad_mask);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            m_beat++;
            d = m_lfsr[7:0];
            if (m_beat == bad_beat) d = d ^ bad_mask;
            beat(d);
            m_lfsr = m_next(m_lfsr);
            repeat (gap) tick();
        end
    endtask

    task automatic run_step(input int idx, input step_t s);
        case (s.op)
            OP_START:  pulse_start();
            OP_CLEAR:  pulse_clear();
            OP_FILL:   do_fill(s.n, s.gap);
            OP_STREAM: do_stream(s.n, s.gap, s.bad_beat, s.bad_mask);
            default:   ;
        endcase
        chk_out($sformatf("step%0d", idx), s.exp_busy, s.exp_done, s.exp_err, s.exp_cnt);
    endtask

    initial begin
        //            op         n     gap bad mask   busy  done  err    cnt
        steps[0]  = '{OP_STREAM, 1021, 0,  0,  8'h00, 1'b1, 1'b0, 8'h00, 16'd0};
        steps[1]  = '{OP_STREAM, 1,    0,  0,  8'h00, 1'b0, 1'b1, 8'h00, 16'd0};
        steps[2]  = '{OP_CLEAR,  0,    0,  0,  8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
        steps[3]  = '{OP_START,  0,    0,  0,  8'h00, 1'b1, 1'b0, 8'h00, 16'd0};
        steps[4]  = '{OP_FILL,   16,   0,  0,  8'h00, 1'b1, 1'b0, 8'h00, 16'd0};
        steps[5]  = '{OP_STREAM, 4,    0,  0,  8'h00, 1'b1, 1'b0, 8'h00, 16'd0};
        steps[6]  = '{OP_STREAM, 1,    0,  5,  8'h08, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[7]  = '{OP_STREAM, 1018, 0,  0,  8'h00, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[8]  = '{OP_STREAM, 1,    0,  0,  8'h00, 1'b0, 1'b1, 8'h08, 16'd1};
        steps[9]  = '{OP_FILL,   3,    0,  0,  8'h00, 1'b0, 1'b1, 8'h08, 16'd1};
        steps[10] = '{OP_START,  0,    0,  0,  8'h00, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[11] = '{OP_FILL,   9,    1,  0,  8'h00, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[12] = '{OP_FILL,   1,    0,  0,  8'h00, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[13] = '{OP_FILL,   6,    1,  0,  8'h00, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[14] = '{OP_STREAM, 1023, 1,  0,  8'h00, 1'b1, 1'b0, 8'h08, 16'd1};
        steps[15] = '{OP_STREAM, 1,    1,  0,  8'h00, 1'b0, 1'b1, 8'h08, 16'd1};
        steps[16] = '{OP_CLEAR,  0,    0,  0,  8'h00, 1'b0, 1'b0, 8'h00, 16'd0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        m_lfsr        = SEED;
        m_beat        = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 1'b0, 8'h00, 16'd0);
        chk("reset dut4 err_count", 32'(bus4.err_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // First run: fill, then the first two stream words as literal constants
        pulse_start();
        do_fill(16, 0);
        chk_out("after fill", 1'b1, 1'b0, 8'h00, 16'd0);
        beat(8'hE1);
        chk_out("beat1 E1", 1'b1, 1'b0, 8'h00, 16'd0);
        chk("beat1 dut4 err_count", 32'(bus4.err_count), 32'd1);
        chk("beat1 dut4 error", 32'(bus4.error), 32'hFF);
        beat(8'hC3);
        chk_out("beat2 C3", 1'b1, 1'b0, 8'h00, 16'd0);
        chk("beat2 dut4 err_count", 32'(bus4.err_count), 32'd2);
        m_lfsr = m_next(m_next(SEED));
        m_beat = 2;

        for (int i = 0; i < NSTEPS; i++) begin
            run_step(i, steps[i]);
            if (i == 1) begin
                chk("sat dut4 err_count", 32'(bus4.err_count), 32'd15);
                chk("sat dut4 error", 32'(bus4.error), 32'hFF);
                chk("sat dut4 done", 32'(bus4.done), 32'd1);
            end
        end
        chk("cleared dut4 err_count", 32'(bus4.err_count), 32'd0);

        // Registered compare, then reset in the middle of CHECK
        pulse_start();
        do_fill(16, 0);
        do_stream(1, 0, 0, 8'h00);
        bus.din_valid = 1'b1;
        bus.din       = m_lfsr[7:0] ^ 8'hFF;
        #1;
        chk("pre-edge error", 32'(bus.error), 32'h00);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        chk_out("post-edge", 1'b1, 1'b0, 8'hFF, 16'd1);
        rst_n = 1'b0;
        #1;
        chk_out("mid reset", 1'b0, 1'b0, 8'h00, 16'd0);
        #2;
        rst_n = 1'b1;
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk_out("clear+start", 1'b0, 1'b0, 8'h00, 16'd0);
        tick();
        chk_out("idle hold", 1'b0, 1'b0, 8'h00, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
